// File: rtl/rs_unified_pkg.sv
// Shared definitions for the unified reservation station.
//   - Default sizing constants for the RS and its surrounding interface.
//   - FU type encoding. The issue channel index equals the FU type code.
package rs_unified_pkg;

  localparam int unsigned RS_NUM_ENTRIES  = 8;
  localparam int unsigned RS_NUM_FU_TYPES = 4;
  localparam int unsigned RS_NUM_CDB      = 2;
  localparam int unsigned RS_XLEN         = 32;
  localparam int unsigned RS_TAG_W        = 5;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LD  = 2'd1,
    FU_ST  = 2'd2,
    FU_FP  = 2'd3
  } fu_type_e;

endpackage

// File: rtl/rs_unified_if.sv
// Bundle of dispatch, CDB and issue signals around the unified RS.
//   master : dispatch/CDB/FU side (drives alloc_*, cdb_*, issue_ready, squash)
//   slave  : the reservation station (drives alloc_ready, issue_*, free_count)
interface rs_unified_if
  import rs_unified_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = RS_NUM_ENTRIES,
  parameter int unsigned NUM_FU_TYPES = RS_NUM_FU_TYPES,
  parameter int unsigned NUM_CDB      = RS_NUM_CDB,
  parameter int unsigned XLEN         = RS_XLEN,
  parameter int unsigned TAG_W        = RS_TAG_W
);
  localparam int unsigned FU_W  = (NUM_FU_TYPES > 1) ? $clog2(NUM_FU_TYPES) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  logic                                    squash;

  logic                                    alloc_valid;
  logic                                    alloc_ready;
  logic [FU_W-1:0]                         alloc_fu;
  logic [TAG_W-1:0]                        alloc_dest;
  logic                                    alloc_rdy1;
  logic                                    alloc_rdy2;
  logic [TAG_W-1:0]                        alloc_t1;
  logic [TAG_W-1:0]                        alloc_t2;
  logic [XLEN-1:0]                         alloc_v1;
  logic [XLEN-1:0]                         alloc_v2;

  logic [NUM_CDB-1:0]                      cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0]           cdb_tag;
  logic [NUM_CDB-1:0][XLEN-1:0]            cdb_value;

  logic [NUM_FU_TYPES-1:0]                 issue_valid;
  logic [NUM_FU_TYPES-1:0]                 issue_ready;
  logic [NUM_FU_TYPES-1:0][XLEN-1:0]       issue_v1;
  logic [NUM_FU_TYPES-1:0][XLEN-1:0]       issue_v2;
  logic [NUM_FU_TYPES-1:0][TAG_W-1:0]      issue_dest;

  logic [CNT_W-1:0]                        free_count;

  modport master (
    output squash,
    output alloc_valid, alloc_fu, alloc_dest, alloc_rdy1, alloc_rdy2,
    output alloc_t1, alloc_t2, alloc_v1, alloc_v2,
    output cdb_valid, cdb_tag, cdb_value,
    output issue_ready,
    input  alloc_ready, issue_valid, issue_v1, issue_v2, issue_dest, free_count
  );

  modport slave (
    input  squash,
    input  alloc_valid, alloc_fu, alloc_dest, alloc_rdy1, alloc_rdy2,
    input  alloc_t1, alloc_t2, alloc_v1, alloc_v2,
    input  cdb_valid, cdb_tag, cdb_value,
    input  issue_ready,
    output alloc_ready, issue_valid, issue_v1, issue_v2, issue_dest, free_count
  );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder.
//   req    : request vector
//   onehot : one-hot of the lowest set request bit ('0 if none)
//   idx    : binary index of that bit ('0 if none)
//   found  : at least one request bit set
module rs_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_unified.sv
// Unified reservation station: any entry may hold any FU type, one issue
// channel per FU type, operand wakeup from NUM_CDB result buses.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears every entry
//   bus     : slave side of rs_unified_if (alloc, CDB, issue, squash, free_count)
// Allocation takes the lowest free entry; each channel issues the lowest ready
// entry of its type. alloc_ready/free_count look only at registered busy bits,
// so an entry issued this cycle is not reusable until the next one.
module rs_unified
  import rs_unified_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = RS_NUM_ENTRIES,
  parameter int unsigned NUM_FU_TYPES = RS_NUM_FU_TYPES,
  parameter int unsigned NUM_CDB      = RS_NUM_CDB,
  parameter int unsigned XLEN         = RS_XLEN,
  parameter int unsigned TAG_W        = RS_TAG_W
) (
  input  logic         clock,
  input  logic         reset_n,
  rs_unified_if.slave  bus
);

  localparam int unsigned FU_W  = (NUM_FU_TYPES > 1) ? $clog2(NUM_FU_TYPES) : 1;
  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  typedef struct packed {
    logic             busy;
    logic [FU_W-1:0]  fu;
    logic             rdy1;
    logic             rdy2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [TAG_W-1:0] dest;
  } rs_entry_t;

  rs_entry_t rs_q [NUM_ENTRIES];
  rs_entry_t rs_d [NUM_ENTRIES];
  rs_entry_t new_entry;

  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0] cdb_tag;
  logic [NUM_CDB-1:0][XLEN-1:0]  cdb_value;

  assign cdb_valid = bus.cdb_valid;
  assign cdb_tag   = bus.cdb_tag;
  assign cdb_value = bus.cdb_value;

  // Returns {hit, value}; the lowest-index matching bus wins.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]            tag,
    input logic [NUM_CDB-1:0]          vld,
    input logic [NUM_CDB-1:0][TAG_W-1:0] tags,
    input logic [NUM_CDB-1:0][XLEN-1:0]  vals
  );
    logic [XLEN:0] r;
    r = '0;
    for (int unsigned b = 0; b < NUM_CDB; b++) begin
      if (!r[XLEN] && vld[b] && (tags[b] == tag)) begin
        r = {1'b1, vals[b]};
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- allocation
  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] alloc_onehot;
  logic [IDX_W-1:0]       alloc_idx_unused;
  logic                   alloc_found;
  logic                   alloc_fire;
  logic [CNT_W-1:0]       free_cnt;

  always_comb begin
    free_vec = '0;
    free_cnt = '0;
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      free_vec[e] = !rs_q[e].busy;
      if (!rs_q[e].busy) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  rs_prio_enc #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_alloc_enc (
    .req    (free_vec),
    .onehot (alloc_onehot),
    .idx    (alloc_idx_unused),
    .found  (alloc_found)
  );

  assign bus.alloc_ready = alloc_found;
  assign bus.free_count  = free_cnt;
  assign alloc_fire      = bus.alloc_valid && alloc_found;

  // A source that is not ready at dispatch may still be satisfied by a CDB
  // broadcast in the same cycle; otherwise the tag would be missed forever.
  always_comb begin
    logic [XLEN:0] cap1;
    logic [XLEN:0] cap2;
    cap1 = cdb_lookup(bus.alloc_t1, cdb_valid, cdb_tag, cdb_value);
    cap2 = cdb_lookup(bus.alloc_t2, cdb_valid, cdb_tag, cdb_value);
    new_entry      = '0;
    new_entry.busy = 1'b1;
    new_entry.fu   = bus.alloc_fu;
    new_entry.dest = bus.alloc_dest;
    new_entry.t1   = bus.alloc_t1;
    new_entry.t2   = bus.alloc_t2;
    new_entry.rdy1 = bus.alloc_rdy1 || cap1[XLEN];
    new_entry.rdy2 = bus.alloc_rdy2 || cap2[XLEN];
    new_entry.v1   = bus.alloc_rdy1 ? bus.alloc_v1 : cap1[XLEN-1:0];
    new_entry.v2   = bus.alloc_rdy2 ? bus.alloc_v2 : cap2[XLEN-1:0];
  end

  // -------------------------------------------------------------------- select
  logic [NUM_FU_TYPES-1:0][NUM_ENTRIES-1:0] sel_req;
  logic [NUM_FU_TYPES-1:0][NUM_ENTRIES-1:0] sel_onehot;
  logic [NUM_FU_TYPES-1:0][IDX_W-1:0]       sel_idx;
  logic [NUM_FU_TYPES-1:0]                  sel_found;
  logic [NUM_ENTRIES-1:0]                   issue_clr;

  always_comb begin
    sel_req = '0;
    for (int unsigned f = 0; f < NUM_FU_TYPES; f++) begin
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
        sel_req[f][e] = rs_q[e].busy && (rs_q[e].fu == FU_W'(f)) &&
                        rs_q[e].rdy1 && rs_q[e].rdy2;
      end
    end
  end

  for (genvar g = 0; g < NUM_FU_TYPES; g++) begin : g_issue_enc
    rs_prio_enc #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_issue_enc (
      .req    (sel_req[g]),
      .onehot (sel_onehot[g]),
      .idx    (sel_idx[g]),
      .found  (sel_found[g])
    );
  end

  always_comb begin
    bus.issue_valid = sel_found;
    bus.issue_v1    = '0;
    bus.issue_v2    = '0;
    bus.issue_dest  = '0;
    issue_clr       = '0;
    for (int unsigned f = 0; f < NUM_FU_TYPES; f++) begin
      if (sel_found[f]) begin
        bus.issue_v1[f]   = rs_q[sel_idx[f]].v1;
        bus.issue_v2[f]   = rs_q[sel_idx[f]].v2;
        bus.issue_dest[f] = rs_q[sel_idx[f]].dest;
        if (bus.issue_ready[f]) issue_clr = issue_clr | sel_onehot[f];
      end
    end
  end

  // ---------------------------------------------------------------- next state
  // Wakeup and issue apply to busy entries, allocation only to a free one, so
  // they never collide on an entry; squash is applied last to override all.
  always_comb begin
    logic [XLEN:0] w1;
    logic [XLEN:0] w2;
    w1 = '0;
    w2 = '0;
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      rs_d[e] = rs_q[e];
      w1 = cdb_lookup(rs_q[e].t1, cdb_valid, cdb_tag, cdb_value);
      w2 = cdb_lookup(rs_q[e].t2, cdb_valid, cdb_tag, cdb_value);
      if (rs_q[e].busy) begin
        if (!rs_q[e].rdy1 && w1[XLEN]) begin
          rs_d[e].rdy1 = 1'b1;
          rs_d[e].v1   = w1[XLEN-1:0];
        end
        if (!rs_q[e].rdy2 && w2[XLEN]) begin
          rs_d[e].rdy2 = 1'b1;
          rs_d[e].v2   = w2[XLEN-1:0];
        end
        if (issue_clr[e]) rs_d[e].busy = 1'b0;
      end
      if (alloc_fire && alloc_onehot[e]) rs_d[e] = new_entry;
      if (bus.squash) rs_d[e].busy = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) rs_q[e] <= '0;
    end else begin
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) rs_q[e] <= rs_d[e];
    end
  end

endmodule
